// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Instruction-fetch program counter generator. Issues
//                sequential fetch addresses to instruction memory with a
//                valid/ready handshake, supports pipeline stall, branch
//                redirect (with a one-entry pending target while a request
//                waits), and a sticky misaligned-redirect error state.
//
//  Ports
//    clk_i            : clock, rising edge
//    rst_i            : asynchronous active-high reset
//    ready_i          : instruction memory accepts the current request
//    stall_i          : pause fetch after the current request is accepted
//    redirect_i       : single-cycle branch/jump redirect strobe
//    redirect_addr_i  : redirect target
//    pc_o             : current fetch address (registered)
//    ce_o             : fetch request valid (registered)
//    err_o            : sticky misaligned-redirect flag (registered)
//    err_addr_o       : offending redirect target (registered)
//
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter int                STEP       = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ready_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    // STEP is a power of two, so the low log2(STEP) bits are exactly STEP-1.
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] C_STEP_INC   = ADDR_W'(STEP);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic w_misaligned;
    logic w_accept;

    assign w_misaligned = redirect_i && ((redirect_addr_i & C_ALIGN_MASK) != '0);
    assign w_accept     = ce_q && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_HOLD;
            pc_q        <= RESET_ADDR;
            ce_q        <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            S_HOLD: begin
                // Redirects are ignored here; fetch always starts at RESET_ADDR.
                state_d = S_RUN;
                ce_d    = 1'b1;
                pc_d    = RESET_ADDR;
            end

            S_RUN: begin
                if (w_misaligned) begin
                    // Error overrides accept, stall and any pending target.
                    state_d    = S_ERR;
                    ce_d       = 1'b0;
                    err_d      = 1'b1;
                    err_addr_d = redirect_addr_i;
                    pend_vld_d = 1'b0;
                end else if (w_accept) begin
                    // Same-cycle redirect beats the pending target.
                    if (redirect_i) begin
                        pc_d = redirect_addr_i;
                    end else if (pend_vld_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        pc_d = pc_q + C_STEP_INC;
                    end
                    pend_vld_d = 1'b0;
                    if (stall_i) begin
                        state_d = S_STALL;
                        ce_d    = 1'b0;
                    end
                end else if (redirect_i) begin
                    // Request is waiting: pc_o must stay stable, so park the
                    // target. A newer redirect simply overwrites it.
                    pend_vld_d  = 1'b1;
                    pend_addr_d = redirect_addr_i;
                end
            end

            S_STALL: begin
                if (w_misaligned) begin
                    state_d    = S_ERR;
                    ce_d       = 1'b0;
                    err_d      = 1'b1;
                    err_addr_d = redirect_addr_i;
                    pend_vld_d = 1'b0;
                end else begin
                    // No request outstanding, so a redirect can load pc directly.
                    if (redirect_i) begin
                        pc_d = redirect_addr_i;
                    end
                    if (!stall_i) begin
                        state_d = S_RUN;
                        ce_d    = 1'b1;
                    end
                end
            end

            S_ERR: begin
                // Terminal until reset.
            end

            default: begin
                state_d = S_HOLD;
                ce_d    = 1'b0;
            end
        endcase
    end

    assign pc_o       = pc_q;
    assign ce_o       = ce_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen. Directed scenarios followed
//                by randomized traffic, compared against a behavioural model
//                of the fetch rules. A second 8-bit instance covers wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b0;
    logic        ready    = 1'b1;
    logic        stall    = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] raddr    = '0;
    logic [31:0] pc;
    logic        ce;
    logic        err;
    logic [31:0] err_addr;

    logic        rst8      = 1'b0;
    logic        ready8    = 1'b1;
    logic        stall8    = 1'b0;
    logic        redirect8 = 1'b0;
    logic [7:0]  raddr8    = '0;
    logic [7:0]  pc8;
    logic        ce8;
    logic        err8;
    logic [7:0]  err_addr8;

    pc_gen #(.ADDR_W(32), .STEP(4), .RESET_ADDR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .ready_i(ready), .stall_i(stall),
        .redirect_i(redirect), .redirect_addr_i(raddr),
        .pc_o(pc), .ce_o(ce), .err_o(err), .err_addr_o(err_addr)
    );

    pc_gen #(.ADDR_W(8), .STEP(4), .RESET_ADDR(8'h0)) dut8 (
        .clk_i(clk), .rst_i(rst8), .ready_i(ready8), .stall_i(stall8),
        .redirect_i(redirect8), .redirect_addr_i(raddr8),
        .pc_o(pc8), .ce_o(ce8), .err_o(err8), .err_addr_o(err_addr8)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- behavioural reference model ----------------
    bit          m_started;   // first edge after reset has happened
    bit          m_paused;    // fetch paused by stall
    bit          m_dead;      // misaligned redirect seen
    logic [31:0] m_pc;
    logic [31:0] m_err_addr;
    logic [31:0] m_pend[$];   // at most one parked redirect target

    function automatic void model_reset();
        m_started  = 1'b0;
        m_paused   = 1'b0;
        m_dead     = 1'b0;
        m_pc       = 32'h0;
        m_err_addr = 32'h0;
        m_pend.delete();
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_dead) return;
        if (!m_started) begin
            m_started = 1'b1;
            return;
        end
        if (redirect && (raddr % 4 != 0)) begin
            m_dead     = 1'b1;
            m_err_addr = raddr;
            m_pend.delete();
            return;
        end
        if (m_paused) begin
            if (redirect) m_pc = raddr;
            if (!stall) m_paused = 1'b0;
            return;
        end
        if (ready) begin
            if (redirect)              m_pc = raddr;
            else if (m_pend.size() > 0) m_pc = m_pend[0];
            else                       m_pc = m_pc + 32'd4;
            m_pend.delete();
            if (stall) m_paused = 1'b1;
        end else if (redirect) begin
            m_pend.delete();
            m_pend.push_back(raddr);
        end
    endfunction

    task automatic check(input string tag);
        logic exp_ce;
        exp_ce = m_started && !m_paused && !m_dead;
        tests += 4;
        assert (pc === m_pc) else begin
            fails++;
            $error("FAIL %s pc: got %h want %h", tag, pc, m_pc);
        end
        assert (ce === exp_ce) else begin
            fails++;
            $error("FAIL %s ce: got %b want %b", tag, ce, exp_ce);
        end
        assert (err === m_dead) else begin
            fails++;
            $error("FAIL %s err: got %b want %b", tag, err, m_dead);
        end
        assert (err_addr === m_err_addr) else begin
            fails++;
            $error("FAIL %s err_addr: got %h want %h", tag, err_addr, m_err_addr);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Advance one edge, update the model with the inputs seen at that edge,
    // then sample outputs 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        model_reset();
        #1;
        rst  = 1'b1;
        rst8 = 1'b1;
        #2;
        check("reset_async");
        expect_val("reset8_pc", 32'(pc8), 32'h0);
        expect_val("reset8_ce", 32'(ce8), 32'h0);
        tick("reset_hold0");
        tick("reset_hold1");

        // Sequential fetch after release
        rst = 1'b0;
        tick("seq0");  expect_val("seq0_pc", pc, 32'h0); expect_val("seq0_ce", 32'(ce), 32'h1);
        tick("seq1");  expect_val("seq1_pc", pc, 32'h4);
        tick("seq2");  expect_val("seq2_pc", pc, 32'h8);
        tick("seq3");  expect_val("seq3_pc", pc, 32'hC);
        tick("seq4");  expect_val("seq4_pc", pc, 32'h10);

        // Wait for ready with two redirects; the newest wins
        ready = 1'b0;
        tick("wait0");
        redirect = 1'b1; raddr = 32'h100;
        tick("wait1");
        raddr = 32'h200;
        tick("wait2");  expect_val("wait_hold_pc", pc, 32'h10);
        redirect = 1'b0; ready = 1'b1;
        tick("wait_acc"); expect_val("pend_taken_pc", pc, 32'h200);

        // Accept with stall for 4 cycles
        redirect = 1'b1; raddr = 32'h20;
        tick("to20");   expect_val("to20_pc", pc, 32'h20);
        redirect = 1'b0; stall = 1'b1;
        tick("stall0"); expect_val("stall_pc", pc, 32'h24); expect_val("stall_ce", 32'(ce), 32'h0);
        repeat (3) tick("stallN");
        stall = 1'b0;
        tick("unstall"); expect_val("unstall_pc", pc, 32'h24); expect_val("unstall_ce", 32'(ce), 32'h1);

        // Redirect during stall loads pc directly
        stall = 1'b1;
        tick("stall_b");
        redirect = 1'b1; raddr = 32'h80;
        tick("stall_redir"); expect_val("stall_redir_pc", pc, 32'h80);
        redirect = 1'b0; stall = 1'b0;
        tick("stall_rel");

        // Pending target overridden by same-cycle redirect at accept
        ready = 1'b0; redirect = 1'b1; raddr = 32'h300;
        tick("pend_a");
        ready = 1'b1; raddr = 32'h400;
        tick("pend_b"); expect_val("sameredir_pc", pc, 32'h400);
        redirect = 1'b0;
        tick("pend_c"); expect_val("pend_cleared_pc", pc, 32'h404);

        // Asynchronous reset pulse in STALL with a redirect present
        stall = 1'b1;
        tick("pre_rst_stall");
        redirect = 1'b1; raddr = 32'h500;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("async_pulse");
        #1 rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick("post_pulse0"); expect_val("post_pulse_pc", pc, 32'h0);
        tick("post_pulse1"); expect_val("post_pulse1_pc", pc, 32'h4);

        // Reset while a redirect is pending: target is dropped
        ready = 1'b0; redirect = 1'b1; raddr = 32'h600;
        tick("pend_rst_a");
        rst = 1'b1; redirect = 1'b0;
        tick("pend_rst_b");
        rst = 1'b0; ready = 1'b1;
        tick("pend_rst_c");
        tick("pend_rst_d"); expect_val("pend_dropped_pc", pc, 32'h4);

        // Misaligned redirect -> sticky error
        redirect = 1'b1; raddr = 32'h40;
        tick("to40");
        raddr = 32'h102;
        tick("misal"); expect_val("misal_err_addr", err_addr, 32'h102);
        expect_val("misal_pc", pc, 32'h40);
        for (int i = 0; i < 6; i++) begin
            redirect = 1'($urandom_range(0, 1));
            raddr    = $urandom;
            ready    = 1'($urandom_range(0, 1));
            stall    = 1'($urandom_range(0, 1));
            tick("err_sticky");
        end
        expect_val("sticky_err", 32'(err), 32'h1);
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; ready = 1'b1;
        tick("err_rst");
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 6) == 0);
            redirect = ($urandom_range(0, 4) == 0);
            raddr    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 39) == 0) raddr[1:0] = 2'($urandom_range(1, 3));
            rst      = (m_dead && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            tick("rand");
        end
        rst = 1'b0;

        // 8-bit wrap from 0xFC to 0x00
        rst8 = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            logic [7:0] e8;
            @(posedge clk);
            #1;
            e8 = 8'((k - 1) * 4);
            expect_val("wrap8_pc", 32'(pc8), 32'(e8));
            expect_val("wrap8_err", 32'(err8), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter STEP, default 4, byte increment per accepted fetch; power of two, at least 1.
REQ-003 Parameter RESET_ADDR, default 0, first fetch address after reset; must be STEP-aligned.
REQ-004 Port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 Port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 Port ready_i  input  1  instruction memory accepts the current fetch request.
REQ-007 Port stall_i  input  1  pipeline requests that fetch pauses after the current request is accepted.
REQ-008 Port redirect_i  input  1  branch/jump redirect strobe, single cycle.
REQ-009 Port redirect_addr_i  input  ADDR_W  redirect target address.
REQ-010 Port pc_o  output  ADDR_W  current fetch address.
REQ-011 Port ce_o  output  1  fetch request valid (chip enable to instruction memory).
REQ-012 Port err_o  output  1  misaligned-redirect error flag; sticky.
REQ-013 Port err_addr_o  output  ADDR_W  offending redirect target.

Function
REQ-014 FSM states: HOLD, RUN, STALL, ERR; encoding is internal.
REQ-015 HOLD: ce_o=0 and pc_o=RESET_ADDR; unconditional move to RUN on the first clock edge after rst_i deasserts.
REQ-016 RUN: ce_o=1; accept = ce_o & ready_i.
REQ-017 Valid rule: while ce_o=1 and ready_i=0, pc_o and ce_o are held stable; redirects in this condition do not change pc_o.
REQ-018 Accept without redirect or pending: next pc_o = pc_o + STEP, modulo 2^ADDR_W. Wrap from all-ones-minus-(STEP-1) to 0 is legal and silent.
REQ-019 Redirect in the same cycle as accept: next pc_o = redirect_addr_i.
REQ-020 Redirect while a request is waiting for ready_i: target is captured in a one-entry pending register.
REQ-021 A later redirect before acceptance overwrites the pending target; the newest redirect wins.
REQ-022 On acceptance with pending valid: next pc_o = pending target, and pending is cleared.
REQ-023 Accept with a same-cycle redirect while pending valid: the same-cycle redirect wins and pending is cleared.
REQ-024 Accept with stall_i=1: move to STALL; pc_o updates per REQ-018..023; ce_o=0 from the next cycle.
REQ-025 stall_i=1 without accept has no effect on RUN (per REQ-017).
REQ-026 STALL: ce_o=0 and pc_o holds its value. A redirect in STALL loads pc_o directly on the next edge; pending is not used.
REQ-027 STALL -> RUN on the first edge with stall_i=0; ce_o=1 in the following cycle with the held or redirected pc_o.
REQ-028 Alignment check: a redirect target is misaligned when redirect_addr_i[log2(STEP)-1:0] is nonzero. The check is applied at capture time in every state except HOLD and ERR.
REQ-029 On a misaligned redirect, the next state is ERR. On that edge: err_o=1, err_addr_o=target, ce_o=0, pc_o holds, and pending is cleared.
REQ-030 Misaligned-redirect priority: a misaligned redirect overrides accept, stall_i and pending.
REQ-031 ERR is terminal until reset; all inputs are ignored.
REQ-032 Redirects in HOLD are ignored.
REQ-033 The block contains no combinational path from inputs to ce_o or pc_o; all outputs are registered.

Reset
REQ-034 While rst_i=1, outputs are forced immediately (asynchronously): pc_o=RESET_ADDR, ce_o=0, err_o=0, err_addr_o=0; state=HOLD; pending cleared.
REQ-035 Reset asserted mid-request aborts the request with no memory handshake obligation.
REQ-036 Release of rst_i is assumed to be synchronised externally to clk_i.

Verification
REQ-037 Reset release, ready_i=1 constant (defaults): pc_o sequence 0 (ce_o=0), 0, 4, 8, 12 with ce_o=1 from the second cycle.
REQ-038 ready_i=0 for 3 cycles at pc_o=0x10 with redirect to 0x100 in the 2nd cycle and to 0x200 in the 3rd: pc_o stays 0x10; after accept, pc_o=0x200.
REQ-039 Accept at pc_o=0x20 with stall_i=1 held for 4 cycles: ce_o=0 and pc_o=0x24 during the stall; ce_o=1 at 0x24 after release.
REQ-040 Redirect to 0x102 (STEP=4) at pc_o=0x40: err_o=1, err_addr_o=0x102, ce_o=0, pc_o=0x40. Output stays unchanged despite further redirects until rst_i.
REQ-041 ADDR_W=8, pc_o=0xFC accepted: next pc_o=0x00, err_o=0.
REQ-042 rst_i pulsed asynchronously (between edges) during STALL with pending redirect: outputs return to reset values immediately; the pending redirect is not applied after release.
